// File: rtl/dp_pkg.sv
// Shared types and constants for the dedicated datapath.
// Holds the ALU opcode encoding, register-file geometry and the
// write-back mux select value that picks the constant source.
package dp_pkg;

    localparam int unsigned REG_CNT = 8;
    localparam int unsigned ADDR_W  = 3;

    // Write-back mux select value that chooses the constant 1 over the ALU.
    localparam logic RF_SRC_CONST = 1'b1;

    // Opcodes 110 and 111 are unassigned and produce a zero result.
    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b010,
        OR  = 3'b011,
        XOR = 3'b100,
        NOT = 3'b101
    } alu_op_e;

endpackage

// File: rtl/register_file.sv
// 8-entry register file: two combinational read ports, one write port.
// R0 is hardwired to zero and ignores writes. There is no write-to-read
// bypass, so a register written on an edge is visible after that edge.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   raddr1/rdata1    read port 1
//   raddr2/rdata2    read port 2
//   we/waddr/wdata   write port, applied on the rising edge
module register_file
    import dp_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs [REG_CNT];

    // Storage update; reset wins over any write in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(REG_CNT); i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Explicit zero for R0 so its reads never depend on storage contents.
    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
    end

endmodule

// File: rtl/dedicated_datapath.sv
// Datapath driven by the cumulative-adder control FSM's control word.
// Register file feeding an ALU, a write-back mux (ALU result or
// constant 1), a registered output buffer with a capture counter, and
// the aBTb comparator flag that is returned to the FSM.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   RFSrcMuxSel         write-back source (1 = constant 1, 0 = ALU)
//   readAddr1/2         register read addresses (ALU operands A/B)
//   writeAddr, writeEn  register write address and enable
//   outBuf              capture read port 1 into outPort
//   aluOP               ALU opcode
//   aBTb                combinational rdata1 > rdata2 (unsigned)
//   outPort             registered captured value
//   outValid            one-cycle pulse after each capture
//   outCount            saturating capture count since reset
module dedicated_datapath
    import dp_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RFSrcMuxSel,
    input  logic [ADDR_W-1:0] readAddr1,
    input  logic [ADDR_W-1:0] readAddr2,
    input  logic [ADDR_W-1:0] writeAddr,
    input  logic              writeEn,
    input  logic              outBuf,
    input  logic [2:0]        aluOP,
    output logic              aBTb,
    output logic [DATA_W-1:0] outPort,
    output logic              outValid,
    output logic [CNT_W-1:0]  outCount
);

    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] wdata;

    register_file #(
        .DATA_W (DATA_W)
    ) u_rf (
        .clk    (clk),
        .reset  (reset),
        .raddr1 (readAddr1),
        .raddr2 (readAddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .we     (writeEn),
        .waddr  (writeAddr),
        .wdata  (wdata)
    );

    // ALU; all results wrap modulo 2^DATA_W, unassigned opcodes give 0.
    always_comb begin
        alu_result = '0;
        case (aluOP)
            ADD:     alu_result = rdata1 + rdata2;
            SUB:     alu_result = rdata1 - rdata2;
            AND:     alu_result = rdata1 & rdata2;
            OR:      alu_result = rdata1 | rdata2;
            XOR:     alu_result = rdata1 ^ rdata2;
            NOT:     alu_result = ~rdata1;
            default: alu_result = '0;
        endcase
    end

    // Write-back source select.
    assign wdata = (RFSrcMuxSel == RF_SRC_CONST) ? DATA_W'(1) : alu_result;

    // Comparator flag back to the FSM; R0 vs R0 is naturally 0.
    assign aBTb = (rdata1 > rdata2);

    // Output buffer captures the pre-write read-port value.
    always_ff @(posedge clk) begin
        if (reset) begin
            outPort  <= '0;
            outValid <= 1'b0;
            outCount <= '0;
        end else if (outBuf) begin
            outPort  <= rdata1;
            outValid <= 1'b1;
            if (outCount != '1) begin
                outCount <= outCount + CNT_W'(1);
            end
        end else begin
            outValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dedicated_datapath.sv
// Self-checking bench for dedicated_datapath: directed control-word
// steps, a register-file reference model, and a scoreboard queue of
// expected outPort captures.
module tb_dedicated_datapath;

    logic       clk;
    logic       reset;
    logic       RFSrcMuxSel;
    logic [2:0] readAddr1;
    logic [2:0] readAddr2;
    logic [2:0] writeAddr;
    logic       writeEn;
    logic       outBuf;
    logic [2:0] aluOP;
    logic       aBTb;
    logic [7:0] outPort;
    logic       outValid;
    logic [7:0] outCount;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_regs [8];
    int         m_cnt;
    logic [7:0] m_out;
    logic [7:0] sb [$];

    dedicated_datapath #(
        .DATA_W (8),
        .CNT_W  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .RFSrcMuxSel (RFSrcMuxSel),
        .readAddr1   (readAddr1),
        .readAddr2   (readAddr2),
        .writeAddr   (writeAddr),
        .writeEn     (writeEn),
        .outBuf      (outBuf),
        .aluOP       (aluOP),
        .aBTb        (aBTb),
        .outPort     (outPort),
        .outValid    (outValid),
        .outCount    (outCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a ^ b;
            3'b101:  return ~a;
            default: return 8'h00;
        endcase
    endfunction

    // One control-word cycle; cap_exp is the value outPort must capture when ob=1.
    task automatic run_cycle(input string tag, input logic src, input logic [2:0] ra1,
                             input logic [2:0] ra2, input logic [2:0] wa, input logic we,
                             input logic ob, input logic [2:0] op, input logic [7:0] cap_exp);
        logic [7:0] wd;
        logic [7:0] got;
        reset       = 1'b0;
        RFSrcMuxSel = src;
        readAddr1   = ra1;
        readAddr2   = ra2;
        writeAddr   = wa;
        writeEn     = we;
        outBuf      = ob;
        aluOP       = op;
        #1;
        if (!$isunknown(ra2)) begin
            check({tag, ".aBTb"}, 32'(aBTb), 32'(m_regs[ra1] > m_regs[ra2]));
        end
        if (ob) sb.push_back(cap_exp);
        wd = 8'h00;
        if (we) wd = src ? 8'h01 : alu_model(op, m_regs[ra1], m_regs[ra2]);
        @(posedge clk);
        #1;
        if (we && (wa != 3'd0)) m_regs[wa] = wd;
        if (ob && (m_cnt < 255)) m_cnt++;
        check({tag, ".outValid"}, 32'(outValid), 32'(ob));
        if (ob) begin
            if (sb.size() == 0) begin
                check({tag, ".sb_empty"}, 32'(sb.size()), 32'd1);
            end else begin
                got = sb.pop_front();
                m_out = got;
            end
        end
        check({tag, ".outPort"}, 32'(outPort), 32'(m_out));
        check({tag, ".outCount"}, 32'(outCount), 32'(m_cnt));
    endtask

    task automatic wr(input string tag, input logic src, input logic [2:0] wa,
                      input logic [2:0] ra1, input logic [2:0] ra2, input logic [2:0] op);
        run_cycle(tag, src, ra1, ra2, wa, 1'b1, 1'b0, op, 8'h00);
    endtask

    // Capture a register and require a literal value.
    task automatic show(input string tag, input logic [2:0] ra, input logic [7:0] lit);
        run_cycle(tag, 1'b0, ra, 3'd0, 3'd0, 1'b0, 1'b1, 3'b000, lit);
    endtask

    task automatic do_reset(input string tag, input logic we, input logic ob);
        reset       = 1'b1;
        RFSrcMuxSel = 1'b1;
        readAddr1   = 3'd1;
        readAddr2   = 3'd0;
        writeAddr   = 3'd3;
        writeEn     = we;
        outBuf      = ob;
        aluOP       = 3'b000;
        @(posedge clk);
        #1;
        reset = 1'b0;
        foreach (m_regs[i]) m_regs[i] = 8'h00;
        m_cnt = 0;
        m_out = 8'h00;
        sb.delete();
        check({tag, ".outValid"}, 32'(outValid), 32'd0);
        check({tag, ".outPort"}, 32'(outPort), 32'd0);
        check({tag, ".outCount"}, 32'(outCount), 32'd0);
    endtask

    initial begin
        foreach (m_regs[i]) m_regs[i] = 8'h00;
        m_cnt = 0;
        m_out = 8'h00;
        reset = 1'b1; RFSrcMuxSel = 1'b0; readAddr1 = 3'd0; readAddr2 = 3'd0;
        writeAddr = 3'd0; writeEn = 1'b0; outBuf = 1'b0; aluOP = 3'b000;
        repeat (2) @(posedge clk);
        #1;

        // Reset with writeEn and outBuf asserted must leave everything clear.
        do_reset("rst", 1'b1, 1'b1);
        for (int a = 0; a < 8; a++) show("rst_read", 3'(a), 8'h00);

        // Control program, each write followed by a show of the destination.
        wr("p_r1", 1'b1, 3'd1, 3'd0, 3'd0, 3'b000);
        wr("p_r4", 1'b0, 3'd4, 3'd1, 3'd1, 3'b000); show("s_r4", 3'd4, 8'h02);
        wr("p_r5", 1'b0, 3'd5, 3'd4, 3'd4, 3'b000); show("s_r5", 3'd5, 8'h04);
        wr("p_r6", 1'b0, 3'd6, 3'd5, 3'd1, 3'b001); show("s_r6", 3'd6, 8'h03);
        wr("p_r2", 1'b0, 3'd2, 3'd6, 3'd4, 3'b010); show("s_r2", 3'd2, 8'h02);
        wr("p_r3", 1'b0, 3'd3, 3'd2, 3'd5, 3'b011); show("s_r3", 3'd3, 8'h06);
        wr("p_r7", 1'b0, 3'd7, 3'd3, 3'd2, 3'b100); show("s_r7", 3'd7, 8'h04);
        wr("p_r7n", 1'b0, 3'd7, 3'd7, 3'd0, 3'b101); show("s_r7n", 3'd7, 8'hFB);
        show("s_r1", 3'd1, 8'h01);

        // X on aluOP/readAddr2 with writeEn low must not disturb state.
        run_cycle("xcyc", 1'b0, 3'd5, 3'bxxx, 3'd0, 1'b0, 1'b1, 3'bxxx, 8'h04);
        show("x_r7", 3'd7, 8'hFB);

        // Write to R0 is ignored; R0 vs R0 compares as 0.
        wr("r0_wr", 1'b0, 3'd0, 3'd5, 3'd1, 3'b000);
        show("r0_rd", 3'd0, 8'h00);
        run_cycle("r0_flag", 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'b000, 8'h00);

        // R1 = 9, R2 = 3, then check the comparator both ways.
        wr("ld_r7", 1'b1, 3'd7, 3'd0, 3'd0, 3'b000);
        wr("ld_r1a", 1'b0, 3'd1, 3'd5, 3'd5, 3'b000);
        wr("ld_r1b", 1'b0, 3'd1, 3'd1, 3'd7, 3'b000);
        wr("ld_r2", 1'b0, 3'd2, 3'd6, 3'd0, 3'b011);
        show("s9", 3'd1, 8'h09);
        run_cycle("gt12", 1'b0, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 3'b000, 8'h00);
        check("gt12_lit", 32'(aBTb), 32'd1);
        run_cycle("gt21", 1'b0, 3'd2, 3'd1, 3'd0, 1'b0, 1'b0, 3'b000, 8'h00);
        check("gt21_lit", 32'(aBTb), 32'd0);

        // Wrap-around cases.
        wr("w_r1", 1'b0, 3'd1, 3'd0, 3'd0, 3'b101);
        wr("w_r2", 1'b1, 3'd2, 3'd0, 3'd0, 3'b000);
        wr("w_add", 1'b0, 3'd3, 3'd1, 3'd2, 3'b000); show("s_add", 3'd3, 8'h00);
        wr("w_sub", 1'b0, 3'd3, 3'd0, 3'd2, 3'b001); show("s_sub", 3'd3, 8'hFF);
        wr("w_110", 1'b0, 3'd3, 3'd1, 3'd2, 3'b110); show("s_110", 3'd3, 8'h00);
        wr("w_111", 1'b0, 3'd1, 3'd1, 3'd2, 3'b111); show("s_111", 3'd1, 8'h00);

        // Simultaneous write and capture of the same register.
        wr("sim_r2", 1'b0, 3'd2, 3'd4, 3'd0, 3'b011);
        wr("sim_r6", 1'b0, 3'd6, 3'd2, 3'd5, 3'b011);
        run_cycle("sim", 1'b0, 3'd3, 3'd6, 3'd3, 1'b1, 1'b1, 3'b011, 8'h00);
        show("sim_next", 3'd3, 8'h06);

        // Saturating capture counter, then reset mid-run.
        for (int n = 0; n < 300; n++) begin
            run_cycle("cnt", 1'b0, 3'd3, 3'd0, 3'd0, 1'b0, 1'b1, 3'b000, m_regs[3]);
        end
        check("cnt_sat", 32'(outCount), 32'd255);
        do_reset("mid_rst", 1'b1, 1'b1);
        show("post_rst", 3'd3, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
